// File: rtl/rv_seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Optional feature macro: RV_SEQ_LOOP_EN (see rv_instr_sequencer.sv).
package rv_seq_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } seq_state_t;
endpackage

// File: rtl/rv_instr_sequencer_if.sv
// Program load port: valid/ready word handshake.
// Master drives words, slave (the sequencer) accepts them.
interface rv_instr_sequencer_if
  import rv_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/rv_seq_prog_mem.sv
// Program store: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module rv_seq_prog_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/rv_instr_sequencer.sv
// Instruction source for the single-cycle core: load, run, redirect.
// Define RV_SEQ_LOOP_EN to replay the program LOOPS times on fall-off.
module rv_instr_sequencer
  import rv_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 64,
  parameter int LOOPS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  rv_instr_sequencer_if.slave      ld,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic [XLEN-1:0]          instruction,
  output logic [XLEN-1:0]          pc,
  output logic                     instr_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  seq_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_q, err_d;

  logic            accept;
  logic [CW-1:0]   count_acc;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] next_pc;
  logic            misal;
  logic            oob;
  logic            is_ebreak;

  assign ld.ld_ready = (state_q == ST_IDLE) && !clear
                    && (count_q < CW'(DEPTH));
  assign accept    = ld.ld_valid && ld.ld_ready;
  assign count_acc = count_q + CW'(accept);

  rv_seq_prog_mem #(
    .XLEN (XLEN),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (accept),
    .waddr(count_q[AW-1:0]),
    .wdata(ld.ld_data),
    .raddr(pc_q[AW+1:2]),
    .rdata(rdata)
  );

  assign next_pc   = redirect ? redirect_pc : pc_q + XLEN'(4);
  assign misal     = |next_pc[1:0];
  assign oob       = (next_pc >> 2) >= XLEN'(count_q);
  assign is_ebreak = rdata == XLEN'(EBREAK_INSTR);

`ifdef RV_SEQ_LOOP_EN
  localparam int LW = $clog2(LOOPS+1);
  logic [LW-1:0] loop_q, loop_d;
  logic          wrap;

  // Only a sequential fall-off replays; a bad redirect always ends.
  assign wrap = !redirect && (loop_q != LW'(LOOPS-1));
`else
  logic unused_loops;
  assign unused_loops = (LOOPS > 0);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
`ifdef RV_SEQ_LOOP_EN
    loop_d  = loop_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = '0;
          err_d   = 1'b0;
          pc_d    = '0;
        end else begin
          count_d = count_acc;
          if (start && (count_acc != '0)) begin
            state_d = ST_RUN;
            pc_d    = '0;
`ifdef RV_SEQ_LOOP_EN
            loop_d  = '0;
`endif
          end
        end
      end
      ST_RUN: begin
        if (misal) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (oob) begin
`ifdef RV_SEQ_LOOP_EN
          if (wrap) begin
            pc_d   = '0;
            loop_d = loop_q + LW'(1);
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else if (is_ebreak) begin
          state_d = ST_DONE;
        end else begin
          pc_d = next_pc;
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d = ST_IDLE;
          count_d = '0;
          err_d   = 1'b0;
          pc_d    = '0;
        end else if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          err_d   = 1'b0;
`ifdef RV_SEQ_LOOP_EN
          loop_d  = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef RV_SEQ_LOOP_EN
      loop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
`ifdef RV_SEQ_LOOP_EN
      loop_q  <= loop_d;
`endif
    end
  end

  assign instruction = (state_q == ST_RUN) ? rdata : XLEN'(NOP_INSTR);
  assign instr_valid = state_q == ST_RUN;
  assign busy        = state_q == ST_RUN;
  assign done        = state_q == ST_DONE;
  assign err         = err_q;
  assign pc          = pc_q;
  assign count       = count_q;
endmodule

// File: tb/tb_rv_instr_sequencer.sv
// Directed bench for rv_instr_sequencer with an issue scoreboard.
// Loop-mode steps build only with RV_SEQ_LOOP_EN.
module tb_rv_instr_sequencer;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] EBRK = 32'h00100073;

  logic        clk = 1'b0;
  logic        reset, clear, start, redirect;
  logic [31:0] redirect_pc, instruction, pc;
  logic        instr_valid, busy, done, err;
  logic [6:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  rv_instr_sequencer_if #(.XLEN(32)) ld ();

  rv_instr_sequencer #(
    .XLEN (32),
    .DEPTH(DEPTH),
    .LOOPS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld         (ld),
    .clear      (clear),
    .start      (start),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instruction(instruction),
    .pc         (pc),
    .instr_valid(instr_valid),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    ld.ld_valid = 1'b1;
    ld.ld_data  = w;
    tick();
    ld.ld_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc  = p;
    e.ins = i;
    q.push_back(e);
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wipe();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_count", 32'(count), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_instr"}, instruction, NOP);
    chk({tag, "_ivalid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_ready"}, 32'(ld.ld_ready), 32'd1);
  endtask

  // Pops one expected issue per valid cycle until done or bound.
  task automatic watch(input int bound, input bit rd_en,
                       input logic [31:0] rd_at,
                       input logic [31:0] rd_tgt,
                       input bit exp_err);
    exp_t e;
    for (int i = 0; i < bound && !done; i++) begin
      if (instr_valid) begin
        if (q.size() == 0) begin
          chk("extra_issue_pc", pc, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("issue_pc", pc, e.pc);
          chk("issue_instr", instruction, e.ins);
        end
      end
      redirect    = rd_en && instr_valid && (pc == rd_at);
      redirect_pc = rd_tgt;
      tick();
    end
    redirect = 1'b0;
    chk("run_done", 32'(done), 32'd1);
    chk("run_err", 32'(err), 32'(exp_err));
    chk("done_instr", instruction, NOP);
    chk("done_ivalid", 32'(instr_valid), 32'd0);
    chk("left_in_queue", q.size(), 32'd0);
    q.delete();
  endtask

  initial begin
    reset       = 1'b1;
    clear       = 1'b0;
    start       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ld.ld_valid = 1'b0;
    ld.ld_data  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    go();
    chk("empty_start_busy", 32'(busy), 32'd0);

    // Linear run; last word accepted together with start
    load(32'h00100093);
    load(32'h002081B3);
    ld.ld_valid = 1'b1;
    ld.ld_data  = 32'h0030A023;
    start       = 1'b1;
    tick();
    ld.ld_valid = 1'b0;
    start       = 1'b0;
    chk("lin_count", 32'(count), 32'd3);
    push(32'h0, 32'h00100093);
    push(32'h4, 32'h002081B3);
    push(32'h8, 32'h0030A023);
    watch(10, 1'b0, 32'h0, 32'h0, 1'b0);

    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clrstart_busy", 32'(busy), 32'd0);
    chk("clrstart_done", 32'(done), 32'd0);
    chk("clrstart_count", 32'(count), 32'd0);

    // Redirect from pc 4 to 0xC skips word 2
    for (int i = 0; i < 4; i++) load(32'hA000_0000 + i);
    push(32'h0, 32'hA000_0000);
    push(32'h4, 32'hA000_0001);
    push(32'hC, 32'hA000_0003);
    go();
    watch(10, 1'b1, 32'h4, 32'hC, 1'b0);
    wipe();

    load(32'hB000_0000);
    load(EBRK);
    load(32'hB000_0002);
    push(32'h0, 32'hB000_0000);
    push(32'h4, EBRK);
    go();
    watch(10, 1'b0, 32'h0, 32'h0, 1'b0);
    wipe();

    for (int i = 0; i < 4; i++) load(32'hC000_0000 + i);
    push(32'h0, 32'hC000_0000);
    push(32'h4, 32'hC000_0001);
    go();
    watch(10, 1'b1, 32'h4, 32'h6, 1'b1);
    // Restart from DONE keeps the program and clears err
    for (int i = 0; i < 4; i++) push(32'(4 * i), 32'hC000_0000 + i);
    go();
    watch(10, 1'b0, 32'h0, 32'h0, 1'b0);
    wipe();

    ld.ld_valid = 1'b1;
    for (int i = 0; i < 65; i++) begin
      ld.ld_data = 32'h1000 + i;
      tick();
      if (i == 63) begin
        chk("cap_count64", 32'(count), 32'd64);
        chk("cap_ready64", 32'(ld.ld_ready), 32'd0);
      end
    end
    ld.ld_valid = 1'b0;
    chk("cap_count65", 32'(count), 32'd64);
    chk("cap_ready65", 32'(ld.ld_ready), 32'd0);
    for (int i = 0; i < 64; i++) push(32'(4 * i), 32'h1000 + i);
    go();
    watch(80, 1'b0, 32'h0, 32'h0, 1'b0);
    wipe();

    for (int i = 0; i < 4; i++) load(32'hD000_0000 + i);
    go();
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_pc", pc, 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("midrst");

`ifdef RV_SEQ_LOOP_EN
    load(32'hE000_0000);
    load(32'hE000_0001);
    for (int i = 0; i < 3; i++) begin
      push(32'h0, 32'hE000_0000);
      push(32'h4, 32'hE000_0001);
    end
    go();
    watch(20, 1'b0, 32'h0, 32'h0, 1'b0);
    wipe();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_instr_sequencer.md
# rv_instr_sequencer

Parametrised, synthesizable instruction source for `single_cycle_riscV`, the next generation of the hand-written per-cycle instruction stimulus. It holds a program of up to DEPTH words, loaded through a valid/ready port. It issues one instruction per clock at a registered PC, follows branch and jump redirects reported by the core, and stops on program end, EBREAK or a misaligned target. It sits between the bench or host loader and the core's `instruction` input.

## Interface
- XLEN, 32, instruction and PC width
- DEPTH, 64, program capacity in words (power of two, ≥2)
- LOOPS, 4, replay count; used only with loop mode
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ld_valid  in  1  program word offered
- ld_data  in  XLEN  program word
- ld_ready  out  1  word can be accepted
- clear  in  1  empty the program (IDLE/DONE only)
- start  in  1  begin execution at PC 0
- redirect  in  1  core took a branch/jump this cycle
- redirect_pc  in  XLEN  target address
- instruction  out  XLEN  instruction to core
- pc  out  XLEN  address of `instruction`
- instr_valid  out  1  `instruction` is a program word
- busy  out  1  state is RUN
- done  out  1  state is DONE
- err  out  1  stopped on misaligned redirect
- count  out  $clog2(DEPTH+1)  words loaded

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - ld_ready = (count < DEPTH).
  - A word is accepted when ld_valid && ld_ready. It is written at index count, and count increments.
  - start with count > 0 (after any same-cycle load) → RUN, pc = 0.
  - start with count = 0 is ignored.
- **RUN**
  - instruction = mem[pc[.:2]], instr_valid = 1, ld_ready = 0.
  - Each edge, next_pc = redirect ? redirect_pc : pc + 4.
  - If next_pc[1:0] ≠ 0 → DONE, err = 1.
  - Else if next_pc/4 ≥ count → DONE, err = 0.
  - Else if the current instruction is EBREAK (32'h00100073) → DONE after it has been presented for one cycle.
  - Otherwise pc ← next_pc.
- **DONE**
  - instruction = NOP (32'h00000013), instr_valid = 0.
  - start → RUN at pc 0, program retained, err cleared.
- **clear**
  - In IDLE or DONE: count ← 0, err ← 0, state → IDLE.
  - clear has priority over start and load.
  - Ignored in RUN.
- Program memory contents are not reset; count = 0 makes them invisible.
- Reset values: state IDLE, pc 0, count 0, instruction NOP, instr_valid 0, busy 0, done 0, err 0, ld_ready 1, loop counter 0.
- Reset asserted mid-RUN aborts immediately to reset values.

## Timing
- pc and state are registered. instruction is an asynchronous read of the program memory at the registered pc, gated by state.
- The first program word appears in the cycle after start is sampled.
- redirect and redirect_pc are sampled at the edge ending the cycle in which the branch instruction is presented. The target appears in the next cycle, so there is zero bubble.
- Load throughput: one word per cycle. The word accepted in the same cycle as start is included in the run.
- The EBREAK or last word is presented for exactly one cycle. done rises on the following cycle.

## Configuration
- `RV_SEQ_LOOP_EN` defined:
  - A sequential fall-off past the last word (not a redirect) wraps pc to 0 and increments the loop counter.
  - After LOOPS complete passes → DONE.
  - An out-of-range redirect still ends the run.
- Undefined: the LOOPS parameter is unused and fall-off → DONE on the first pass.

## Structure
- Package `rv_seq_pkg`: state enum, NOP_INSTR, EBREAK_INSTR, XLEN default.
- Sub-module `rv_seq_prog_mem`: DEPTH×XLEN, one synchronous write port, one asynchronous read port.
- Top module holds the FSM, pc, count and loop counter.

## Test plan
- **Linear run.** Load 0x00100093, 0x002081B3, 0x0030A023, then start. Required response: (pc, instruction) = (0, 0x00100093), (4, 0x002081B3), (8, 0x0030A023). Next cycle done = 1, instruction = 0x00000013, err = 0.
- **Redirect.** Load 4 words and pulse redirect with redirect_pc = 0xC while pc = 4. Required response: next pc = 0xC with word 3; word 2 is never issued.
- **EBREAK and misaligned target.**
  - With EBREAK at index 1: done after pc 4, and index 2 is not issued.
  - Separate run, redirect_pc = 0x6: done = 1, err = 1.
- **Capacity.** Hold ld_valid for 65 cycles with DEPTH = 64. Required response: count = 64, ld_ready = 0 from then on, and the 65th word is not written.
- **Clear, restart and reset.**
  - clear and start together in DONE: state IDLE, count = 0.
  - Reset asserted mid-RUN: all outputs return to reset values on the next edge.
- **Loop mode** (`RV_SEQ_LOOP_EN`, LOOPS = 3, 2-word program). Required response: pc sequence 0, 4, 0, 4, 0, 4, then done.
